// File: rtl/clkdiv_pkg.sv
// Shared definitions for the multi-channel clock divider: output modes,
// power-up terminal count and load-index width helper.
package clkdiv_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } clkdiv_mode_e;

  // 12 MHz / (2 * (99999 + 1)) = 60 Hz in toggle mode
  localparam int unsigned CLKDIV_DEFAULT_LIMIT = 99999;

  function automatic int unsigned ch_idx_width(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: wrap-at-limit counter, registered terminal tick and
// a toggle-or-strobe clock output.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned WIDTH         = 17,
  parameter int unsigned DEFAULT_LIMIT = CLKDIV_DEFAULT_LIMIT
) (
  input  logic             clock_in,
  input  logic             nReset,
  input  logic             enable,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             clock_out,
  output logic             tick
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] limit;
  logic             terminal_c;

  assign terminal_c = (count == limit);

  // Load outranks counting, so a terminal coinciding with a load is dropped
  always_ff @(posedge clock_in) begin
    if (!nReset) begin
      count     <= '0;
      limit     <= WIDTH'(DEFAULT_LIMIT);
      tick      <= 1'b0;
      clock_out <= 1'b0;
    end else if (load) begin
      count <= '0;
      limit <= load_value;
      tick  <= 1'b0;
    end else if (enable) begin
      count <= terminal_c ? '0 : count + WIDTH'(1);
      tick  <= terminal_c;
      if (mode == MODE_PULSE) begin
        clock_out <= terminal_c;
      end else if (terminal_c) begin
        clock_out <= ~clock_out;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/clock_divider_n.sv
// N-channel programmable clock divider with a shared limit-load bus.
// Decodes the load target and acknowledges accepted loads one cycle later.
module clock_divider_n
  import clkdiv_pkg::*;
#(
  parameter int unsigned N_CH          = 2,
  parameter int unsigned WIDTH         = 17,
  parameter int unsigned DEFAULT_LIMIT = CLKDIV_DEFAULT_LIMIT
) (
  input  logic                              clock_in,
  input  logic                              nReset,
  input  logic [N_CH-1:0]                   enable,
  input  logic [N_CH-1:0]                   mode,
  input  logic                              load,
  input  logic [ch_idx_width(N_CH)-1:0]     load_ch,
  input  logic [WIDTH-1:0]                  load_value,
  output logic                              load_ack,
  output logic [N_CH-1:0]                   clock_out,
  output logic [N_CH-1:0]                   tick
);

  localparam int unsigned CH_W = ch_idx_width(N_CH);

  logic load_valid_c;

  // Out-of-range channel indices are silently ignored
  assign load_valid_c = load && (32'(load_ch) < N_CH);

  always_ff @(posedge clock_in) begin
    if (!nReset) begin
      load_ack <= 1'b0;
    end else begin
      load_ack <= load_valid_c;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic load_hit_c;

    assign load_hit_c = load_valid_c && (load_ch == CH_W'(c));

    clkdiv_channel #(
      .WIDTH         (WIDTH),
      .DEFAULT_LIMIT (DEFAULT_LIMIT)
    ) u_channel (
      .clock_in   (clock_in),
      .nReset     (nReset),
      .enable     (enable[c]),
      .mode       (mode[c]),
      .load       (load_hit_c),
      .load_value (load_value),
      .clock_out  (clock_out[c]),
      .tick       (tick[c])
    );
  end

endmodule

// File: tb/tb_clock_divider_n.sv
// Scoreboard bench for clock_divider_n: the driver queues hand-computed
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_clock_divider_n;

  localparam int unsigned N_CH  = 3;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned DLIM  = 3;

  logic             clock_in = 1'b0;
  logic             nReset;
  logic [2:0]       enable;
  logic [2:0]       mode;
  logic             load;
  logic [1:0]       load_ch;
  logic [WIDTH-1:0] load_value;
  logic             load_ack;
  logic [2:0]       clock_out;
  logic [2:0]       tick;

  typedef struct {
    logic [2:0] co;
    logic [2:0] tk;
    logic       ack;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  clock_divider_n #(
    .N_CH          (N_CH),
    .WIDTH         (WIDTH),
    .DEFAULT_LIMIT (DLIM)
  ) dut (
    .clock_in   (clock_in),
    .nReset     (nReset),
    .enable     (enable),
    .mode       (mode),
    .load       (load),
    .load_ch    (load_ch),
    .load_value (load_value),
    .load_ack   (load_ack),
    .clock_out  (clock_out),
    .tick       (tick)
  );

  always #5 clock_in = ~clock_in;

  task automatic chk(input string tag, input string what, input logic [2:0] act, input logic [2:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s %s: got %b expected %b at %0t", tag, what, act, req, $time);
    end
  endtask

  // Monitor: one expectation per clock edge, sampled mid-cycle
  always @(negedge clock_in) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk(e.tag, "clock_out", clock_out, e.co);
      chk(e.tag, "tick", tick, e.tk);
      chk(e.tag, "load_ack", {2'b00, load_ack}, {2'b00, e.ack});
    end
  end

  // Queue the outputs expected after the next rising edge, then take it
  task automatic cyc(input logic [2:0] co, input logic [2:0] tk, input logic ack, input string tag);
    exp_t e;
    e.co  = co;
    e.tk  = tk;
    e.ack = ack;
    e.tag = tag;
    sb_q.push_back(e);
    @(posedge clock_in);
    #1;
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    cyc(3'b000, 3'b000, 1'b0, "reset");
    nReset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    logic b;
    nReset     = 1'b0;
    enable     = 3'b111;
    mode       = 3'b000;
    load       = 1'b0;
    load_ch    = 2'd0;
    load_value = '0;

    // Default limit 3, toggle mode: tick every 4, clock_out period 8
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      a = (k % 4 == 0);
      b = ((k / 4) % 2 == 1);
      cyc({3{b}}, {3{a}}, 1'b0, "toggle_default");
    end

    // Load ch1 with limit 0: ack next cycle, ch1 toggles every cycle
    load = 1'b1; load_ch = 2'd1; load_value = 4'd0;
    cyc(3'b000, 3'b000, 1'b1, "load_ch1");
    load = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      a = (j % 4 == 3);
      b = (j >= 3 && j < 7);
      cyc({b, logic'(j % 2 == 1), b}, {a, 1'b1, a}, 1'b0, "limit0_ch1");
    end

    // Pulse mode on ch0 with limit 2: strobe 1 of every 3 cycles
    do_reset();
    enable = 3'b001; mode = 3'b001;
    load = 1'b1; load_ch = 2'd0; load_value = 4'd2;
    cyc(3'b000, 3'b000, 1'b1, "load_ch0_pulse");
    load = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      a = (j % 3 == 0);
      cyc({2'b00, a}, {2'b00, a}, 1'b0, "pulse_lim2");
    end

    // Enable gap mid-count: count and clock_out hold, tick stays low
    do_reset();
    enable = 3'b001; mode = 3'b000;
    for (int k = 1; k <= 6; k++)
      cyc({2'b00, logic'(k >= 4)}, {2'b00, logic'(k == 4)}, 1'b0, "pre_gap");
    enable = 3'b000;
    for (int k = 1; k <= 5; k++)
      cyc(3'b001, 3'b000, 1'b0, "gap_hold");
    enable = 3'b001;
    for (int r = 1; r <= 6; r++)
      cyc({2'b00, logic'(r == 1 || r == 6)}, {2'b00, logic'(r == 2 || r == 6)}, 1'b0, "resume");

    // Load landing on the terminal cycle suppresses tick and toggle
    do_reset();
    enable = 3'b001; mode = 3'b000;
    for (int k = 1; k <= 3; k++)
      cyc(3'b000, 3'b000, 1'b0, "pre_term");
    load = 1'b1; load_ch = 2'd0; load_value = 4'd1;
    cyc(3'b000, 3'b000, 1'b1, "load_on_term");
    load = 1'b0;
    for (int j = 1; j <= 6; j++)
      cyc({2'b00, logic'((j / 2) % 2 == 1)}, {2'b00, logic'(j % 2 == 0)}, 1'b0, "after_term_load");
    // Out-of-range channel: ignored, limit 1 keeps running
    load = 1'b1; load_ch = 2'd3; load_value = 4'd0;
    cyc(3'b001, 3'b000, 1'b0, "bad_ch_load");
    load = 1'b0;
    cyc(3'b000, 3'b001, 1'b0, "bad_ch_after");

    // Reset mid-period with a load pending: load discarded, defaults back
    do_reset();
    enable = 3'b111; mode = 3'b000;
    for (int k = 1; k <= 5; k++)
      cyc((k >= 4) ? 3'b111 : 3'b000, (k == 4) ? 3'b111 : 3'b000, 1'b0, "pre_midreset");
    nReset = 1'b0; load = 1'b1; load_ch = 2'd0; load_value = 4'd0;
    cyc(3'b000, 3'b000, 1'b0, "midreset");
    nReset = 1'b1; load = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      a = (k % 4 == 0);
      b = ((k / 4) % 2 == 1);
      cyc({3{b}}, {3{a}}, 1'b0, "post_midreset");
    end

    @(negedge clock_in);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
